regfile_mw_arb: RTL and testbench

- Multi-writer register file: three independent write requesters with valid/ready handshakes share one physical write port through a round-robin arbiter.
- Two combinational read ports.
- A post-reset initialisation sweep writes a known pattern into every entry at one entry per cycle, replacing single-cycle whole-array reset.
- Serves the write side of a shared register store whose consumers are plain multi-read ports.

---
 rtl/regfile_mw_arb.sv | 148 ++++++++++++++
 tb/tb_regfile_mw_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mw_arb.sv
// Register file with three round-robin arbitrated write requesters and two combinational read ports.
// After reset, an init sweep fills one entry per cycle before any write is granted.
module regfile_mw_arb #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int lo = 0,
    parameter int hi = 31,
    parameter logic [data_width-1:0] init_value = 32'hAAAAAAAA
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WVALID_0,
    input  logic [addr_width-1:0] WADDR_0,
    input  logic [data_width-1:0] WDATA_0,
    output logic                  WREADY_0,
    input  logic                  WVALID_1,
    input  logic [addr_width-1:0] WADDR_1,
    input  logic [data_width-1:0] WDATA_1,
    output logic                  WREADY_1,
    input  logic                  WVALID_2,
    input  logic [addr_width-1:0] WADDR_2,
    input  logic [data_width-1:0] WDATA_2,
    output logic                  WREADY_2,
    input  logic [addr_width-1:0] RADDR_1,
    output logic [data_width-1:0] RDATA_1,
    input  logic [addr_width-1:0] RADDR_2,
    output logic [data_width-1:0] RDATA_2,
    output logic                  INIT_DONE,
    output logic                  ADDR_ERR
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [addr_width-1:0] lo_a = addr_width'(lo);
    localparam logic [addr_width-1:0] hi_a = addr_width'(hi);

    logic [data_width-1:0] arr [lo:hi];

    logic [0:0]            state;
    logic [addr_width-1:0] init_ptr;
    logic [1:0]            rr_ptr;
    logic                  init_done;
    logic                  addr_err;

    logic [2:0]            valid;
    logic [2:0]            gnt;
    logic                  run;
    logic                  xfer;
    logic                  in_range;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_data;

    assign valid = {WVALID_2, WVALID_1, WVALID_0};

    // Grants are suppressed in the reset cycle so an in-flight request is dropped, not completed.
    assign run = (state == ST_RUN) && !RST;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        gnt = 3'b000;
        if (run) begin
            case (rr_ptr)
                2'd1: begin
                    if (valid[1])      gnt = 3'b010;
                    else if (valid[2]) gnt = 3'b100;
                    else if (valid[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if (valid[2])      gnt = 3'b100;
                    else if (valid[0]) gnt = 3'b001;
                    else if (valid[1]) gnt = 3'b010;
                end
                default: begin
                    if (valid[0])      gnt = 3'b001;
                    else if (valid[1]) gnt = 3'b010;
                    else if (valid[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    assign WREADY_0 = gnt[0];
    assign WREADY_1 = gnt[1];
    assign WREADY_2 = gnt[2];
    assign xfer     = |gnt;

    always_comb begin
        sel_addr = WADDR_0;
        sel_data = WDATA_0;
        if (gnt[1]) begin
            sel_addr = WADDR_1;
            sel_data = WDATA_1;
        end else if (gnt[2]) begin
            sel_addr = WADDR_2;
            sel_data = WDATA_2;
        end
    end

    // Zero-extended to int so the bounds compare stays unsigned in value for any lo/hi.
    assign in_range = (int'(sel_addr) >= lo) && (int'(sel_addr) <= hi);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_INIT;
            init_ptr  <= lo_a;
            rr_ptr    <= 2'd0;
            init_done <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_ptr == hi_a) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_ptr <= init_ptr + 1'b1;
                    end
                end
                default: begin
                    if (gnt[0])      rr_ptr <= 2'd1;
                    else if (gnt[1]) rr_ptr <= 2'd2;
                    else if (gnt[2]) rr_ptr <= 2'd0;
                    if (xfer && !in_range) addr_err <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the array is deliberately not reset; the init sweep fills it one entry per cycle instead.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == ST_INIT)
                arr[init_ptr] <= init_value;
            else if (xfer && in_range)
                arr[sel_addr] <= sel_data;
        end
    end

    // No write bypass: a same-cycle write becomes visible after the edge.
    assign RDATA_1 = arr[RADDR_1];
    assign RDATA_2 = arr[RADDR_2];

    assign INIT_DONE = init_done;
    assign ADDR_ERR  = addr_err;

endmodule

// File: tb/tb_regfile_mw_arb.sv
// Directed bench for regfile_mw_arb: a full-range instance and a hi=29 instance for out-of-range writes.
module tb_regfile_mw_arb;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic [2:0]  wvalid;
    logic [4:0]  waddr [3];
    logic [31:0] wdata [3];
    wire  [2:0]  wready;
    logic [4:0]  raddr_1, raddr_2;
    wire  [31:0] rdata_1, rdata_2;
    wire         init_done, addr_err;

    logic [2:0]  b_wvalid;
    logic [4:0]  b_waddr [3];
    logic [31:0] b_wdata [3];
    wire  [2:0]  b_wready;
    logic [4:0]  b_raddr_1, b_raddr_2;
    wire  [31:0] b_rdata_1, b_rdata_2;
    wire         b_init_done, b_addr_err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] INIT_PAT = 32'hAAAAAAAA;

    regfile_mw_arb u_dut (
        .CLK(CLK), .RST(RST),
        .WVALID_0(wvalid[0]), .WADDR_0(waddr[0]), .WDATA_0(wdata[0]), .WREADY_0(wready[0]),
        .WVALID_1(wvalid[1]), .WADDR_1(waddr[1]), .WDATA_1(wdata[1]), .WREADY_1(wready[1]),
        .WVALID_2(wvalid[2]), .WADDR_2(waddr[2]), .WDATA_2(wdata[2]), .WREADY_2(wready[2]),
        .RADDR_1(raddr_1), .RDATA_1(rdata_1),
        .RADDR_2(raddr_2), .RDATA_2(rdata_2),
        .INIT_DONE(init_done), .ADDR_ERR(addr_err)
    );

    regfile_mw_arb #(.hi(29)) u_dut29 (
        .CLK(CLK), .RST(RST),
        .WVALID_0(b_wvalid[0]), .WADDR_0(b_waddr[0]), .WDATA_0(b_wdata[0]), .WREADY_0(b_wready[0]),
        .WVALID_1(b_wvalid[1]), .WADDR_1(b_waddr[1]), .WDATA_1(b_wdata[1]), .WREADY_1(b_wready[1]),
        .WVALID_2(b_wvalid[2]), .WADDR_2(b_waddr[2]), .WDATA_2(b_wdata[2]), .WREADY_2(b_wready[2]),
        .RADDR_1(b_raddr_1), .RDATA_1(b_rdata_1),
        .RADDR_2(b_raddr_2), .RDATA_2(b_rdata_2),
        .INIT_DONE(b_init_done), .ADDR_ERR(b_addr_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts cycles from reset release until INIT_DONE on both instances, with a cycle budget.
    task automatic count_sweep(output int n, output int nb, output bit rdy_seen);
        n = 0;
        nb = 0;
        rdy_seen = 1'b0;
        while (!init_done && n < 100) begin
            tick();
            n++;
            if (!init_done && wready !== 3'b000) rdy_seen = 1'b1;
            if (b_init_done === 1'b1 && nb == 0) nb = n;
        end
    endtask

    task automatic test_reset();
        int n, nb;
        bit rdy_seen;
        RST = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({init_done, addr_err, wready} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_state: init_done/addr_err/wready=%b expected 00000", {init_done, addr_err, wready});
        end
        n_cmp++;
        if ({b_init_done, b_addr_err} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_state_b: init_done/addr_err=%b expected 00", {b_init_done, b_addr_err});
        end
        // Requests held during the sweep must never be granted.
        wvalid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            waddr[i] = 5'd9;
            wdata[i] = 32'h1234;
        end
        RST = 1'b0;
        count_sweep(n, nb, rdy_seen);
        wvalid = 3'b000;
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL init_duration: got %0d cycles expected 32", n);
        end
        n_cmp++;
        if (nb !== 30) begin
            n_bad++;
            $display("FAIL init_duration_b: got %0d cycles expected 30", nb);
        end
        n_cmp++;
        if (rdy_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL wready_in_init: saw a grant during the sweep, expected none");
        end
        for (int i = 0; i < 32; i++) begin
            raddr_1 = 5'(i);
            raddr_2 = 5'(31 - i);
            #1;
            n_cmp++;
            if (rdata_1 !== INIT_PAT) begin
                n_bad++;
                $display("FAIL init_read1[%0d]: got %h expected %h", i, rdata_1, INIT_PAT);
            end
            n_cmp++;
            if (rdata_2 !== INIT_PAT) begin
                n_bad++;
                $display("FAIL init_read2[%0d]: got %h expected %h", 31 - i, rdata_2, INIT_PAT);
            end
        end
    endtask

    task automatic test_contention();
        tick();
        waddr[0] = 5'd1; wdata[0] = 32'd11;
        waddr[1] = 5'd2; wdata[1] = 32'd22;
        waddr[2] = 5'd3; wdata[2] = 32'd33;
        wvalid = 3'b111;
        #1;
        n_cmp++;
        if (wready !== 3'b001) begin
            n_bad++;
            $display("FAIL contention_g0: wready=%b expected 001", wready);
        end
        tick();
        wvalid = 3'b110;
        #1;
        n_cmp++;
        if (wready !== 3'b010) begin
            n_bad++;
            $display("FAIL contention_g1: wready=%b expected 010", wready);
        end
        tick();
        wvalid = 3'b100;
        #1;
        n_cmp++;
        if (wready !== 3'b100) begin
            n_bad++;
            $display("FAIL contention_g2: wready=%b expected 100", wready);
        end
        tick();
        wvalid = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            raddr_1 = 5'(i);
            #1;
            n_cmp++;
            if (rdata_1 !== 32'(11 * i)) begin
                n_bad++;
                $display("FAIL contention_data[%0d]: got %0d expected %0d", i, rdata_1, 11 * i);
            end
        end
        // Port 0 alone right after the rotation wrapped back to it.
        tick();
        waddr[0] = 5'd4; wdata[0] = 32'd44;
        wvalid = 3'b001;
        #1;
        n_cmp++;
        if (wready !== 3'b001) begin
            n_bad++;
            $display("FAIL single_request: wready=%b expected 001", wready);
        end
        tick();
        wvalid = 3'b000;
        raddr_1 = 5'd4;
        #1;
        n_cmp++;
        if (rdata_1 !== 32'd44) begin
            n_bad++;
            $display("FAIL single_data: got %0d expected 44", rdata_1);
        end
    endtask

    // Pointer sits at 1 after the port-0 grant above.
    task automatic test_same_addr();
        tick();
        waddr[0] = 5'd5; wdata[0] = 32'h100;
        waddr[1] = 5'd5; wdata[1] = 32'h200;
        wvalid = 3'b011;
        #1;
        n_cmp++;
        if (wready !== 3'b010) begin
            n_bad++;
            $display("FAIL same_addr_first: wready=%b expected 010", wready);
        end
        tick();
        wvalid = 3'b001;
        #1;
        n_cmp++;
        if (wready !== 3'b001) begin
            n_bad++;
            $display("FAIL same_addr_second: wready=%b expected 001", wready);
        end
        tick();
        wvalid = 3'b000;
        raddr_1 = 5'd5;
        #1;
        n_cmp++;
        if (rdata_1 !== 32'h100) begin
            n_bad++;
            $display("FAIL same_addr_final: got %h expected 00000100", rdata_1);
        end
    endtask

    task automatic test_read_during_write();
        tick();
        waddr[2] = 5'd7; wdata[2] = 32'h5;
        wvalid = 3'b100;
        #1;
        n_cmp++;
        if (wready !== 3'b100) begin
            n_bad++;
            $display("FAIL rdw_setup: wready=%b expected 100", wready);
        end
        tick();
        waddr[0] = 5'd7; wdata[0] = 32'h9;
        wvalid = 3'b001;
        raddr_1 = 5'd7;
        #1;
        n_cmp++;
        if ({wready, rdata_1} !== {3'b001, 32'h5}) begin
            n_bad++;
            $display("FAIL rdw_old: wready=%b rdata=%h expected 001 00000005", wready, rdata_1);
        end
        tick();
        wvalid = 3'b000;
        #1;
        n_cmp++;
        if (rdata_1 !== 32'h9) begin
            n_bad++;
            $display("FAIL rdw_new: got %h expected 00000009", rdata_1);
        end
    endtask

    task automatic test_out_of_range();
        tick();
        b_waddr[1] = 5'd31;
        b_wdata[1] = 32'hDEAD;
        b_wvalid = 3'b010;
        #1;
        n_cmp++;
        if ({b_wready, b_addr_err} !== 4'b0100) begin
            n_bad++;
            $display("FAIL oor_grant: wready/addr_err=%b expected 0100", {b_wready, b_addr_err});
        end
        tick();
        b_wvalid = 3'b000;
        n_cmp++;
        if (b_addr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_flag: addr_err=%b expected 1", b_addr_err);
        end
        tick();
        tick();
        n_cmp++;
        if (b_addr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_sticky: addr_err=%b expected 1", b_addr_err);
        end
        n_cmp++;
        if (addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_isolated: main addr_err=%b expected 0", addr_err);
        end
        for (int i = 0; i < 30; i++) begin
            b_raddr_1 = 5'(i);
            #1;
            n_cmp++;
            if (b_rdata_1 !== INIT_PAT) begin
                n_bad++;
                $display("FAIL oor_unchanged[%0d]: got %h expected %h", i, b_rdata_1, INIT_PAT);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, nb;
        bit rdy_seen;
        tick();
        waddr[2] = 5'd8; wdata[2] = 32'h77;
        wvalid = 3'b100;
        RST = 1'b1;
        raddr_1 = 5'd8;
        #1;
        n_cmp++;
        if (wready !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_drop_ready: wready=%b expected 000", wready);
        end
        tick();
        n_cmp++;
        if ({init_done, rdata_1} !== {1'b0, INIT_PAT}) begin
            n_bad++;
            $display("FAIL rst_drop_write: init_done=%b rdata=%h expected 0 %h", init_done, rdata_1, INIT_PAT);
        end
        n_cmp++;
        if (b_addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_clears_err: addr_err=%b expected 0", b_addr_err);
        end
        wvalid = 3'b000;
        RST = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        RST = 1'b1;
        tick();
        n_cmp++;
        if (init_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_init: init_done=%b expected 0", init_done);
        end
        RST = 1'b0;
        count_sweep(n, nb, rdy_seen);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL restart_duration: got %0d cycles expected 32", n);
        end
        n_cmp++;
        if (nb !== 30) begin
            n_bad++;
            $display("FAIL restart_duration_b: got %0d cycles expected 30", nb);
        end
    endtask

    initial begin
        wvalid = 3'b000;
        b_wvalid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            waddr[i] = '0; wdata[i] = '0;
            b_waddr[i] = '0; b_wdata[i] = '0;
        end
        raddr_1 = '0; raddr_2 = '0;
        b_raddr_1 = '0; b_raddr_2 = '0;

        test_reset();
        test_contention();
        test_same_addr();
        test_read_during_write();
        test_out_of_range();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
